// File: rtl/id_load_interlock.sv
// rtl/id_load_interlock.sv - ID-stage load-use interlock with a multi-entry load tracker
module id_load_interlock #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic                id_rs1_used,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                id_rs2_used,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_is_load,
  input  logic                nullify,
  input  logic                pipe_hold,
  output logic                stall,
  output logic                ex_issue,
  output logic                hazard_rs1,
  output logic                hazard_rs2,
  output logic [LOAD_LAT-1:0] pending,
  output logic [CNT_W-1:0]    stall_count
);

  localparam logic [2:0] LAT3 = 3'(LOAD_LAT);

  logic [LOAD_LAT-1:0] valid_q, valid_d;
  logic [REG_W-1:0]    rd_q  [LOAD_LAT];
  logic [REG_W-1:0]    rd_d  [LOAD_LAT];
  logic [2:0]          cnt_q [LOAD_LAT];
  logic [2:0]          cnt_d [LOAD_LAT];
  logic [CNT_W-1:0]    stall_cnt_q;

  logic rs1_zero, rs2_zero, rd_zero;
  logic rs1_match, rs2_match;
  logic haz;
  logic alloc_req;
  logic alloc_fail;
  logic count_en;

  assign rs1_zero = (ZERO_REG != 0) && (id_rs1 == '0);
  assign rs2_zero = (ZERO_REG != 0) && (id_rs2 == '0);
  assign rd_zero  = (ZERO_REG != 0) && (id_rd == '0);

  always_comb begin
    rs1_match = 1'b0;
    rs2_match = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (valid_q[i] && (cnt_q[i] != 3'd0)) begin
        if (rd_q[i] == id_rs1) rs1_match = 1'b1;
        if (rd_q[i] == id_rs2) rs2_match = 1'b1;
      end
    end
  end

  assign hazard_rs1 = id_valid && id_rs1_used && !rs1_zero && rs1_match;
  assign hazard_rs2 = id_valid && id_rs2_used && !rs2_zero && rs2_match;
  assign haz        = hazard_rs1 || hazard_rs2;

  // Hold outranks nullify: a frozen EX keeps its jump until the hold drops.
  always_comb begin
    stall    = 1'b0;
    ex_issue = 1'b0;
    if (pipe_hold) begin
      stall = 1'b1;
    end else if (nullify) begin
      ex_issue = 1'b0;
    end else if (haz) begin
      stall = 1'b1;
    end else begin
      ex_issue = id_valid;
    end
  end

  assign alloc_req = ex_issue && id_is_load && !rd_zero;
  assign count_en  = !pipe_hold && !nullify && haz;

  always_comb begin
    logic found;
    found      = 1'b0;
    alloc_fail = 1'b0;
    valid_d    = valid_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    if (!pipe_hold) begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        if (valid_q[i]) begin
          if (cnt_q[i] > 3'd1) begin
            cnt_d[i] = cnt_q[i] - 3'd1;
          end else begin
            cnt_d[i]   = 3'd0;
            valid_d[i] = 1'b0;
          end
        end
      end
      // Slots freed by this cycle's decrement are reusable immediately.
      if (alloc_req) begin
        for (int i = 0; i < LOAD_LAT; i++) begin
          if (!found && !valid_d[i]) begin
            found      = 1'b1;
            valid_d[i] = 1'b1;
            rd_d[i]    = id_rd;
            cnt_d[i]   = LAT3;
          end
        end
        alloc_fail = !found;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < LOAD_LAT; i++) begin
        rd_q[i]  <= '0;
        cnt_q[i] <= 3'd0;
      end
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      if (count_en && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pending     = valid_q;
  assign stall_count = stall_cnt_q;

  a_alloc_ok: assert property (@(posedge clk) disable iff (!reset_n) !alloc_fail);

endmodule
